// File: rtl/trafik_kavsak_kontrol_if.sv
// Signal bundle between the intersection controller and the board/requesters.
// master = request side (sensors, button, lamp observer); slave = controller.
// Optional NIGHT_MODE_EN adds the night input.
interface trafik_kavsak_kontrol_if;
`ifdef NIGHT_MODE_EN
    logic       night;
`endif
    logic       side_req;
    logic       ped_req;
    logic       main_red;
    logic       main_yellow;
    logic       main_green;
    logic       side_red;
    logic       side_yellow;
    logic       side_green;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
`ifdef NIGHT_MODE_EN
        output night,
`endif
        output side_req,
        output ped_req,
        input  main_red,
        input  main_yellow,
        input  main_green,
        input  side_red,
        input  side_yellow,
        input  side_green,
        input  ped_walk,
        input  phase
    );

    modport slave (
`ifdef NIGHT_MODE_EN
        input  night,
`endif
        input  side_req,
        input  ped_req,
        output main_red,
        output main_yellow,
        output main_green,
        output side_red,
        output side_yellow,
        output side_green,
        output ped_walk,
        output phase
    );
endinterface

// File: rtl/trafik_kavsak_kontrol.sv
// Two-road intersection scheduler with pedestrian walk phase.
// Main road rests in green; latched side/pedestrian requests start a full
// phase cycle. Phase times are counted in ticks from an internal prescaler.
// All lamp outputs are active-low and registered.
// Optional feature macro: NIGHT_MODE_EN (adds night input and flashing NIGHT state).
module trafik_kavsak_kontrol #(
    parameter int TICK_DIV     = 20_000_000,
    parameter int T_MIN_GREEN  = 10,
    parameter int T_SIDE_GREEN = 5,
    parameter int T_YELLOW     = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_PED        = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    trafik_kavsak_kontrol_if.slave  bus
);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        ALLRED1  = 3'd2,
        SIDE_G   = 3'd3,
        SIDE_Y   = 3'd4,
        ALLRED2  = 3'd5,
        PED_WALK = 3'd6,
        NIGHT    = 3'd7
    } state_t;

    // Largest duration any state counts to; the main-green counter saturates
    // at T_MIN_GREEN so it must be representable as well.
    localparam int T_MAX_0 = (T_MIN_GREEN  > T_SIDE_GREEN) ? T_MIN_GREEN  : T_SIDE_GREEN;
    localparam int T_MAX_1 = (T_YELLOW     > T_ALLRED)     ? T_YELLOW     : T_ALLRED;
    localparam int T_MAX_2 = (T_MAX_0      > T_MAX_1)      ? T_MAX_0      : T_MAX_1;
    localparam int T_MAX   = (T_MAX_2      > T_PED)        ? T_MAX_2      : T_PED;
    localparam int SEC_W   = $clog2(T_MAX + 1);
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Bit positions inside the lamp vector.
    localparam int L_MR = 0;
    localparam int L_MY = 1;
    localparam int L_MG = 2;
    localparam int L_SR = 3;
    localparam int L_SY = 4;
    localparam int L_SG = 5;
    localparam int L_PW = 6;
    localparam int N_LAMPS = 7;

    // Reset shows both heads red, everything else dark (active-low).
    localparam logic [N_LAMPS-1:0] LAMP_RESET = 7'b111_0110;

    state_t             state_reg, state_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [SEC_W-1:0]   sec_reg, sec_next;
    logic               side_pend_reg, side_pend_next;
    logic               ped_pend_reg, ped_pend_next;
    logic [N_LAMPS-1:0] lamp_reg;
    logic [N_LAMPS-1:0] lamp_next;
    logic [N_LAMPS-1:0] lit;
`ifdef NIGHT_MODE_EN
    logic               blink_reg, blink_next;
`endif

    logic tick;
    logic state_change;
    logic min_green_done;

    assign tick           = (pre_reg == PRE_W'(TICK_DIV - 1));
    assign state_change   = (state_next != state_reg);
    // Elapsed time including the current tick has reached the minimum green.
    assign min_green_done = (sec_reg >= SEC_W'(T_MIN_GREEN - 1));

    // Returns true on the tick that completes a state of duration t.
    function automatic logic dur_done(input logic [SEC_W-1:0] sec, input int t);
        return sec == SEC_W'(t - 1);
    endfunction

    // State register, request latches and timebase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ALLRED2;
            pre_reg       <= '0;
            sec_reg       <= '0;
            side_pend_reg <= 1'b0;
            ped_pend_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pre_reg       <= pre_next;
            sec_reg       <= sec_next;
            side_pend_reg <= side_pend_next;
            ped_pend_reg  <= ped_pend_next;
        end
    end

`ifdef NIGHT_MODE_EN
    // Flash phase for the night pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_reg <= 1'b0;
        end else begin
            blink_reg <= blink_next;
        end
    end
`endif

    // One register per lamp, loaded from the decode of the next state so the
    // lamps change on the same edge as the phase code.
    genvar gi;
    generate
        for (gi = 0; gi < N_LAMPS; gi++) begin : g_lamp
            // Lamp output register, bit gi.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lamp_reg[gi] <= LAMP_RESET[gi];
                end else begin
                    lamp_reg[gi] <= lamp_next[gi];
                end
            end
        end
    endgenerate

    // Prescaler and per-state second counter; both restart on any state change.
    always_comb begin
        pre_next = pre_reg;
        sec_next = sec_reg;
        if (state_change) begin
            pre_next = '0;
            sec_next = '0;
        end else if (tick) begin
            pre_next = '0;
            if (state_reg == MAIN_G) begin
                // Saturate so an idle main green never wraps.
                if (sec_reg < SEC_W'(T_MIN_GREEN)) begin
                    sec_next = sec_reg + 1'b1;
                end
            end else if (state_reg != NIGHT) begin
                sec_next = sec_reg + 1'b1;
            end
        end else begin
            pre_next = pre_reg + 1'b1;
        end
    end

    // Next-state logic, request latches and lamp decode.
    always_comb begin
        state_next     = state_reg;
        side_pend_next = side_pend_reg;
        ped_pend_next  = ped_pend_reg;
        lit            = '0;
`ifdef NIGHT_MODE_EN
        blink_next     = blink_reg;
`endif

        case (state_reg)
            MAIN_G: begin
`ifdef NIGHT_MODE_EN
                if (tick && min_green_done && bus.night) begin
                    state_next = NIGHT;
                end else
`endif
                if (tick && min_green_done && (side_pend_reg || ped_pend_reg)) begin
                    state_next = MAIN_Y;
                end
            end
            MAIN_Y: begin
                if (tick && dur_done(sec_reg, T_YELLOW)) state_next = ALLRED1;
            end
            ALLRED1: begin
                if (tick && dur_done(sec_reg, T_ALLRED)) state_next = SIDE_G;
            end
            SIDE_G: begin
                if (tick && dur_done(sec_reg, T_SIDE_GREEN)) state_next = SIDE_Y;
            end
            SIDE_Y: begin
                if (tick && dur_done(sec_reg, T_YELLOW)) state_next = ALLRED2;
            end
            ALLRED2: begin
                if (tick && dur_done(sec_reg, T_ALLRED)) begin
                    state_next = ped_pend_reg ? PED_WALK : MAIN_G;
                end
            end
            PED_WALK: begin
                if (tick && dur_done(sec_reg, T_PED)) state_next = MAIN_G;
            end
            NIGHT: begin
`ifdef NIGHT_MODE_EN
                if (tick && !bus.night) state_next = ALLRED2;
`else
                // Unreachable without the night feature; recover safely.
                state_next = ALLRED2;
`endif
            end
            default: state_next = ALLRED2;
        endcase

        // A latch clears only on the edge that enters its serving state; a
        // request present on that same edge re-arms it immediately.
        if (state_next == SIDE_G && state_reg != SIDE_G) begin
            side_pend_next = 1'b0;
        end
        if (state_next == PED_WALK && state_reg != PED_WALK) begin
            ped_pend_next = 1'b0;
        end
        if (bus.side_req) side_pend_next = 1'b1;
        if (bus.ped_req)  ped_pend_next  = 1'b1;

`ifdef NIGHT_MODE_EN
        // Flash starts lit on entry and toggles every tick while in NIGHT.
        if (state_next == NIGHT && state_reg != NIGHT) begin
            blink_next = 1'b1;
        end else if (state_reg == NIGHT && tick) begin
            blink_next = ~blink_reg;
        end
`endif

        case (state_next)
            MAIN_G:   begin lit[L_MG] = 1'b1; lit[L_SR] = 1'b1; end
            MAIN_Y:   begin lit[L_MY] = 1'b1; lit[L_SR] = 1'b1; end
            SIDE_G:   begin lit[L_MR] = 1'b1; lit[L_SG] = 1'b1; end
            SIDE_Y:   begin lit[L_MR] = 1'b1; lit[L_SY] = 1'b1; end
            PED_WALK: begin lit[L_MR] = 1'b1; lit[L_SR] = 1'b1; lit[L_PW] = 1'b1; end
            NIGHT: begin
`ifdef NIGHT_MODE_EN
                lit[L_MY] = blink_next;
                lit[L_SR] = blink_next;
`else
                lit[L_MR] = 1'b1;
                lit[L_SR] = 1'b1;
`endif
            end
            default:  begin lit[L_MR] = 1'b1; lit[L_SR] = 1'b1; end
        endcase

        lamp_next = ~lit;
    end

    assign bus.main_red    = lamp_reg[L_MR];
    assign bus.main_yellow = lamp_reg[L_MY];
    assign bus.main_green  = lamp_reg[L_MG];
    assign bus.side_red    = lamp_reg[L_SR];
    assign bus.side_yellow = lamp_reg[L_SY];
    assign bus.side_green  = lamp_reg[L_SG];
    assign bus.ped_walk    = lamp_reg[L_PW];
    assign bus.phase       = state_reg;

endmodule

// File: tb/tb_trafik_kavsak_kontrol.sv
// Self-checking bench for trafik_kavsak_kontrol (TICK_DIV=4).
// A cycle-counting model of the phase sequence is compared every cycle;
// directed scenarios add literal duration/value checks. When built with
// NIGHT_MODE_EN a short night-flash scenario runs at the end.
module tb_trafik_kavsak_kontrol;

    localparam int TD    = 4;
    localparam int T_MIN = 10;
    localparam int T_SG  = 5;
    localparam int T_Y   = 2;
    localparam int T_AR  = 1;
    localparam int T_PW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    trafik_kavsak_kontrol_if bus ();

    trafik_kavsak_kontrol #(
        .TICK_DIV     (TD),
        .T_MIN_GREEN  (T_MIN),
        .T_SIDE_GREEN (T_SG),
        .T_YELLOW     (T_Y),
        .T_ALLRED     (T_AR),
        .T_PED        (T_PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    int m_ph    = 5;
    int m_cyc   = 0;
    bit m_sp    = 1'b0;
    bit m_pp    = 1'b0;
    bit m_valid = 1'b0;

    // Phase duration in clock cycles, by phase code.
    function automatic int dur_cycles(input int ph);
        case (ph)
            1, 4:    return T_Y * TD;
            2, 5:    return T_AR * TD;
            3:       return T_SG * TD;
            6:       return T_PW * TD;
            default: return 0;
        endcase
    endfunction

    // Model advances one clock: cycles spent in the phase decide exits.
    always @(posedge clk) begin : model
        int n_ph;
        int n_cyc;
        bit n_sp;
        bit n_pp;
        if (rst) begin
            m_ph    <= 5;
            m_cyc   <= 0;
            m_sp    <= 1'b0;
            m_pp    <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            n_cyc = m_cyc + 1;
            n_ph  = m_ph;
            if (m_ph == 0) begin
                if ((n_cyc % TD == 0) && n_cyc >= T_MIN * TD && (m_sp || m_pp)) n_ph = 1;
            end else if (n_cyc == dur_cycles(m_ph)) begin
                case (m_ph)
                    5:       n_ph = m_pp ? 6 : 0;
                    6:       n_ph = 0;
                    default: n_ph = m_ph + 1;
                endcase
            end
            n_sp = (n_ph == 3 && m_ph != 3) ? 1'b0 : m_sp;
            n_pp = (n_ph == 6 && m_ph != 6) ? 1'b0 : m_pp;
            if (bus.side_req) n_sp = 1'b1;
            if (bus.ped_req)  n_pp = 1'b1;
            if (n_ph != m_ph) n_cyc = 0;
            m_ph  <= n_ph;
            m_cyc <= n_cyc;
            m_sp  <= n_sp;
            m_pp  <= n_pp;
        end
    end

    // Expected active-low lamps {walk, sg, sy, sr, mg, my, mr} for a phase.
    function automatic logic [6:0] exp_lamps(input int ph);
        logic [6:0] lit;
        lit = '0;
        if (ph == 0)      lit[2] = 1'b1;
        else if (ph == 1) lit[1] = 1'b1;
        else              lit[0] = 1'b1;
        if (ph == 3)      lit[5] = 1'b1;
        else if (ph == 4) lit[4] = 1'b1;
        else              lit[3] = 1'b1;
        if (ph == 6)      lit[6] = 1'b1;
        return ~lit;
    endfunction

    logic [6:0] act_lamps;
    assign act_lamps = {bus.ped_walk, bus.side_green, bus.side_yellow, bus.side_red,
                        bus.main_green, bus.main_yellow, bus.main_red};

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && m_valid) begin
            total++;
            if (bus.phase !== 3'(m_ph) || act_lamps !== exp_lamps(m_ph)) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t phase got %0d want %0d lamps got %b want %b",
                         $time, bus.phase, m_ph, act_lamps, exp_lamps(m_ph));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    task automatic wait_phase(input int p, input int budget, input string nm);
        int n = 0;
        while (bus.phase !== 3'(p) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bus.phase), 32'(p));
    endtask

    // Counts cycles the DUT stays in phase p (caller is in p at a negedge).
    task automatic measure(input int p, input int exp, input string nm);
        int n = 0;
        while (bus.phase === 3'(p) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check(nm, 32'(n), 32'(exp));
    endtask

    task automatic pulse_side();
        bus.side_req = 1'b1;
        @(negedge clk);
        bus.side_req = 1'b0;
    endtask

    task automatic pulse_ped();
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
`ifdef NIGHT_MODE_EN
        bus.night    = 1'b0;
`endif
        // Reset and idle.
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk_en = 1'b1;
        check("reset_phase", 32'(bus.phase), 32'd5);
        check("reset_main_red", 32'(bus.main_red), 32'd0);
        check("reset_side_red", 32'(bus.side_red), 32'd0);
        check("reset_main_green_off", 32'(bus.main_green), 32'd1);
        rst = 1'b0;
        idle(3);
        check("allred2_after_3", 32'(bus.phase), 32'd5);
        idle(1);
        check("main_g_after_4", 32'(bus.phase), 32'd0);
        check("main_green_lit", 32'(bus.main_green), 32'd0);
        idle(200);
        check("idle_holds_main_g", 32'(bus.phase), 32'd0);

        // Side request: full side cycle, durations in cycles.
        pulse_side();
        wait_phase(1, 60, "side_enter_main_y");
        measure(1, 8, "main_y_len");
        measure(2, 4, "allred1_len");
        measure(3, 20, "side_g_len");
        measure(4, 8, "side_y_len");
        measure(5, 4, "allred2_len");
        check("side_back_main_g", 32'(bus.phase), 32'd0);

        // Pedestrian request: side cycle then walk.
        idle(5);
        pulse_ped();
        wait_phase(6, 200, "ped_reach_walk");
        check("walk_lit", 32'(bus.ped_walk), 32'd0);
        measure(6, 20, "walk_len");
        check("ped_back_main_g", 32'(bus.phase), 32'd0);
        idle(60);
        check("ped_pend_cleared", 32'(bus.phase), 32'd0);

        // Request on the clearing edge of SIDE_G re-arms the latch.
        pulse_side();
        wait_phase(2, 100, "clr_reach_allred1");
        idle(3);
        bus.side_req = 1'b1;
        @(negedge clk);
        bus.side_req = 1'b0;
        check("clr_enter_side_g", 32'(bus.phase), 32'd3);
        wait_phase(0, 100, "clr_back_main_g");
        measure(0, 40, "clr_second_cycle_min_green");
        check("clr_second_main_y", 32'(bus.phase), 32'd1);

        // Mid-cycle reset clears both latches.
        wait_phase(0, 100, "mid_main_g");
        pulse_side();
        wait_phase(3, 100, "mid_side_g");
        pulse_ped();
        wait_phase(4, 100, "mid_side_y");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_phase", 32'(bus.phase), 32'd5);
        check("mid_rst_reds", 32'({bus.main_red, bus.side_red}), 32'd0);
        measure(5, 4, "mid_allred2_len");
        check("mid_to_main_g", 32'(bus.phase), 32'd0);
        idle(60);
        check("mid_latches_cleared", 32'(bus.phase), 32'd0);

        // Randomized requests and rare resets against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.side_req = ($urandom_range(0, 99) < 3);
            bus.ped_req  = ($urandom_range(0, 99) < 2);
            rst          = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        rst          = 1'b0;

`ifdef NIGHT_MODE_EN
        begin : night_test
            int n;
            chk_en = 1'b0;
            wait_phase(0, 400, "night_main_g");
            idle(44);
            bus.night = 1'b1;
            wait_phase(7, 20, "night_enter");
            check("night_yellow_lit", 32'(bus.main_yellow), 32'd0);
            check("night_green_off", 32'(bus.main_green), 32'd1);
            n = 0;
            while (bus.main_yellow === 1'b0 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("night_lit_len", 32'(n), 32'd4);
            n = 0;
            while (bus.main_yellow === 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("night_dark_len", 32'(n), 32'd4);
            bus.night = 1'b0;
            wait_phase(5, 20, "night_exit_allred2");
            measure(5, 4, "night_allred2_len");
            check("night_back_main_g", 32'(bus.phase), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
